// File: rtl/idu_decode_if.sv
// Fetch/EX-facing bundle of the RV32I decode stage.
// The d_mext field exists only when RV32M_DECODE_EN is defined.
interface idu_decode_if;
  logic [31:0] IR;
  logic [31:0] PC;
  logic        InstrRd;
  logic        doBranch;
  logic        ex_hold;
  logic        ex_memRead;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [4:0]  d_rd;
  logic [31:0] d_imm;
  logic [2:0]  d_funct3;
  logic        d_funct7b5;
  logic        d_regWrite;
  logic        d_memRead;
  logic        d_memWrite;
  logic        d_branch;
  logic        d_jump;
  logic        d_illegal;
`ifdef RV32M_DECODE_EN
  logic        d_mext;
`endif

  modport slave (
    input  IR, PC, InstrRd, doBranch, ex_hold, ex_memRead, ex_rd,
`ifdef RV32M_DECODE_EN
    output d_mext,
`endif
    output stall, d_valid, d_pc, d_rs1, d_rs2, d_rd, d_imm, d_funct3, d_funct7b5,
           d_regWrite, d_memRead, d_memWrite, d_branch, d_jump, d_illegal
  );

  modport master (
    output IR, PC, InstrRd, doBranch, ex_hold, ex_memRead, ex_rd,
`ifdef RV32M_DECODE_EN
    input  d_mext,
`endif
    input  stall, d_valid, d_pc, d_rs1, d_rs2, d_rd, d_imm, d_funct3, d_funct7b5,
           d_regWrite, d_memRead, d_memWrite, d_branch, d_jump, d_illegal
  );
endinterface

// File: rtl/idu_decode.sv
// RV32I decode stage with one-entry skid for load-use bubbles.
// Define RV32M_DECODE_EN to accept M-extension OP encodings (adds d_mext).
module idu_decode (
  input  logic           clk,
  input  logic           resetn,
  idu_decode_if.slave    bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {RUN, BUBBLE} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
`ifdef RV32M_DECODE_EN
    logic        mext;
`endif
  } bundle_t;

  state_t      state_reg, state_next;
  logic [31:0] skid_ir_reg, skid_pc_reg;
  logic        skid_valid_reg;
  logic        d_valid_reg, valid_next;
  bundle_t     bundle_reg, dec;

  logic [31:0] src_ir, src_pc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        wr_class, uses_rs1, uses_rs2, hazard;
  logic        load_bundle, capture, skid_clear;

  // In BUBBLE the held instruction comes from the skid, never from IR.
  assign src_ir = (state_reg == BUBBLE) ? skid_ir_reg : bus.IR;
  assign src_pc = (state_reg == BUBBLE) ? skid_pc_reg : bus.PC;
  assign opcode = src_ir[6:0];
  assign funct3 = src_ir[14:12];
  assign funct7 = src_ir[31:25];

  always_comb begin
    dec           = '0;
    wr_class      = 1'b0;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    dec.pc        = src_pc;
    dec.rs1       = src_ir[19:15];
    dec.rs2       = src_ir[24:20];
    dec.rd        = src_ir[11:7];
    dec.funct3    = funct3;
    dec.funct7b5  = src_ir[30];
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        wr_class = 1'b1;
        dec.imm  = {src_ir[31:12], 12'b0};
      end
      OPC_JAL: begin
        wr_class = 1'b1;
        dec.jump = 1'b1;
        dec.imm  = {{11{src_ir[31]}}, src_ir[31], src_ir[19:12], src_ir[20], src_ir[30:21], 1'b0};
      end
      OPC_JALR: begin
        wr_class = 1'b1;
        uses_rs1 = 1'b1;
        dec.jump = 1'b1;
        dec.imm  = {{20{src_ir[31]}}, src_ir[31:20]};
      end
      OPC_BRANCH: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        dec.branch = 1'b1;
        dec.imm    = {{19{src_ir[31]}}, src_ir[31], src_ir[7], src_ir[30:25], src_ir[11:8], 1'b0};
      end
      OPC_LOAD: begin
        wr_class     = 1'b1;
        uses_rs1     = 1'b1;
        dec.mem_read = 1'b1;
        dec.imm      = {{20{src_ir[31]}}, src_ir[31:20]};
      end
      OPC_STORE: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = {{20{src_ir[31]}}, src_ir[31:25], src_ir[11:7]};
      end
      OPC_OPIMM: begin
        wr_class = 1'b1;
        uses_rs1 = 1'b1;
        dec.imm  = {{20{src_ir[31]}}, src_ir[31:20]};
      end
      OPC_OP: begin
        wr_class = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.illegal = 1'b0;
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.illegal = 1'b0;
`ifdef RV32M_DECODE_EN
        end else if (funct7 == 7'b0000001) begin
          dec.mext = 1'b1;
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_MISC: begin
        dec.imm = {{20{src_ir[31]}}, src_ir[31:20]};
      end
      OPC_SYSTEM: begin
        // Only the register-form CSR ops read rs1; all CSR ops write rd.
        wr_class = (funct3 != 3'b000);
        uses_rs1 = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
        dec.imm  = {{20{src_ir[31]}}, src_ir[31:20]};
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
    end
    dec.reg_write = wr_class && !dec.illegal && (dec.rd != 5'd0);
  end

  assign hazard = (state_reg == RUN) && bus.InstrRd && bus.ex_memRead && (bus.ex_rd != 5'd0) &&
                  ((uses_rs1 && (dec.rs1 == bus.ex_rd)) || (uses_rs2 && (dec.rs2 == bus.ex_rd)));

  always_comb begin
    state_next  = state_reg;
    valid_next  = d_valid_reg;
    load_bundle = 1'b0;
    capture     = 1'b0;
    skid_clear  = 1'b0;
    if (bus.doBranch) begin
      state_next = RUN;
      valid_next = 1'b0;
      skid_clear = 1'b1;
    end else if (!bus.ex_hold) begin
      case (state_reg)
        RUN: begin
          if (hazard) begin
            capture    = 1'b1;
            valid_next = 1'b0;
            state_next = BUBBLE;
          end else begin
            load_bundle = bus.InstrRd;
            valid_next  = bus.InstrRd;
          end
        end
        BUBBLE: begin
          load_bundle = skid_valid_reg;
          valid_next  = skid_valid_reg;
          skid_clear  = 1'b1;
          state_next  = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign bus.stall = resetn && !bus.doBranch && (bus.ex_hold || hazard);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= RUN;
      skid_ir_reg    <= '0;
      skid_pc_reg    <= '0;
      skid_valid_reg <= 1'b0;
      d_valid_reg    <= 1'b0;
      bundle_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      d_valid_reg <= valid_next;
      if (capture) begin
        skid_ir_reg    <= bus.IR;
        skid_pc_reg    <= bus.PC;
        skid_valid_reg <= 1'b1;
      end else if (skid_clear) begin
        skid_valid_reg <= 1'b0;
      end
      if (load_bundle) begin
        bundle_reg <= dec;
      end
    end
  end

  assign bus.d_valid    = d_valid_reg;
  assign bus.d_pc       = bundle_reg.pc;
  assign bus.d_rs1      = bundle_reg.rs1;
  assign bus.d_rs2      = bundle_reg.rs2;
  assign bus.d_rd       = bundle_reg.rd;
  assign bus.d_imm      = bundle_reg.imm;
  assign bus.d_funct3   = bundle_reg.funct3;
  assign bus.d_funct7b5 = bundle_reg.funct7b5;
  assign bus.d_regWrite = bundle_reg.reg_write;
  assign bus.d_memRead  = bundle_reg.mem_read;
  assign bus.d_memWrite = bundle_reg.mem_write;
  assign bus.d_branch   = bundle_reg.branch;
  assign bus.d_jump     = bundle_reg.jump;
  assign bus.d_illegal  = bundle_reg.illegal;
`ifdef RV32M_DECODE_EN
  assign bus.d_mext     = bundle_reg.mext;
`endif

endmodule

// File: tb/tb_idu_decode.sv
// Directed-vector bench for idu_decode; checks both RV32M_DECODE_EN builds.
module tb_idu_decode;
  logic clk;
  logic resetn;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  idu_decode_if bus ();

  idu_decode dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic en, input string name);
    bus.IR      = ir;
    bus.PC      = pc;
    bus.InstrRd = en;
    $display("vec %-12s IR=0x%08h PC=0x%08h InstrRd=%0b", name, ir, pc, en);
  endtask

  initial begin
    resetn         = 1'b1;
    bus.IR         = '0;
    bus.PC         = '0;
    bus.InstrRd    = 1'b0;
    bus.doBranch   = 1'b0;
    bus.ex_hold    = 1'b0;
    bus.ex_memRead = 1'b0;
    bus.ex_rd      = '0;
    #2 resetn = 1'b0;
    #1;
    check("rst_valid", bus.d_valid, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_pc", bus.d_pc, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // addi x1,x0,5
    drive(32'h00500093, 32'h100, 1'b1, "addi");
    #1 check("addi_stall", bus.stall, 0);
    tick();
    check("addi_valid", bus.d_valid, 1);
    check("addi_rd", bus.d_rd, 1);
    check("addi_imm", bus.d_imm, 5);
    check("addi_regw", bus.d_regWrite, 1);
    check("addi_pc", bus.d_pc, 32'h100);

    // load-use on x1: add x2,x1,x2
    bus.ex_memRead = 1'b1;
    bus.ex_rd      = 5'd1;
    drive(32'h00208133, 32'h104, 1'b1, "add_hazard");
    #1 check("lu_stall", bus.stall, 1);
    tick();
    check("lu_bubble", bus.d_valid, 0);
    check("lu_stall_once", bus.stall, 0);
    tick();
    check("lu_valid", bus.d_valid, 1);
    check("lu_rs1", bus.d_rs1, 1);
    check("lu_rs2", bus.d_rs2, 2);
    check("lu_pc", bus.d_pc, 32'h104);

    // ex_rd = x0 never hazards
    bus.ex_rd = 5'd0;
    drive(32'h00500093, 32'h108, 1'b1, "addi_x0src");
    #1 check("x0_stall", bus.stall, 0);
    tick();
    check("x0_valid", bus.d_valid, 1);
    check("x0_pc", bus.d_pc, 32'h108);
    bus.ex_memRead = 1'b0;

    drive(32'hFE000EE3, 32'h200, 1'b1, "beq_m4");
    tick();
    check("beq_imm", bus.d_imm, 32'hFFFFFFFC);
    check("beq_branch", bus.d_branch, 1);
    check("beq_regw", bus.d_regWrite, 0);

    drive(32'hFFFFFFFF, 32'h204, 1'b1, "all_ones");
    tick();
    check("ill_valid", bus.d_valid, 1);
    check("ill_flag", bus.d_illegal, 1);
    check("ill_regw", bus.d_regWrite, 0);
    check("ill_memr", bus.d_memRead, 0);
    check("ill_memw", bus.d_memWrite, 0);

    drive(32'h00100013, 32'h208, 1'b1, "addi_rd0");
    tick();
    check("rd0_regw", bus.d_regWrite, 0);
    check("rd0_ill", bus.d_illegal, 0);

    drive(32'h123452B7, 32'h20C, 1'b1, "lui");
    tick();
    check("lui_imm", bus.d_imm, 32'h12345000);
    check("lui_rd", bus.d_rd, 5);

    drive(32'h0020A423, 32'h210, 1'b1, "sw");
    tick();
    check("sw_imm", bus.d_imm, 8);
    check("sw_memw", bus.d_memWrite, 1);
    check("sw_regw", bus.d_regWrite, 0);

    drive(32'hFFC0A183, 32'h214, 1'b1, "lw_m4");
    tick();
    check("lw_imm", bus.d_imm, 32'hFFFFFFFC);
    check("lw_memr", bus.d_memRead, 1);

    drive(32'h010000EF, 32'h218, 1'b1, "jal_16");
    tick();
    check("jal_imm", bus.d_imm, 16);
    check("jal_jump", bus.d_jump, 1);
    check("jal_regw", bus.d_regWrite, 1);

    // ex_hold freezes outputs and asserts stall
    drive(32'h00500093, 32'h300, 1'b1, "addi_pre");
    tick();
    bus.ex_hold = 1'b1;
    drive(32'h123452B7, 32'h304, 1'b1, "lui_held");
    #1 check("hold_stall", bus.stall, 1);
    tick();
    check("hold_pc", bus.d_pc, 32'h300);
    check("hold_valid", bus.d_valid, 1);
    check("hold_imm", bus.d_imm, 5);
    bus.ex_hold = 1'b0;

    drive(32'h00500093, 32'h308, 1'b0, "idle");
    tick();
    check("idle_valid", bus.d_valid, 0);

    // flush while in BUBBLE discards the skid
    bus.ex_memRead = 1'b1;
    bus.ex_rd      = 5'd1;
    drive(32'h00208133, 32'h400, 1'b1, "add_flush");
    tick();
    check("fl_bubble", bus.d_valid, 0);
    bus.ex_memRead = 1'b0;
    bus.doBranch   = 1'b1;
    drive(32'h0, 32'h0, 1'b0, "flush");
    #1 check("fl_stall", bus.stall, 0);
    tick();
    check("fl_valid", bus.d_valid, 0);
    bus.doBranch = 1'b0;
    tick();
    check("fl_noskid", bus.d_valid, 0);
    drive(32'h00500093, 32'h500, 1'b1, "addi_post");
    tick();
    check("fl_run_valid", bus.d_valid, 1);
    check("fl_run_pc", bus.d_pc, 32'h500);

    drive(32'h02208133, 32'h504, 1'b1, "mul");
    tick();
`ifdef RV32M_DECODE_EN
    check("mul_mext", bus.d_mext, 1);
    check("mul_ill", bus.d_illegal, 0);
    check("mul_regw", bus.d_regWrite, 1);
    check("mul_f7b5", bus.d_funct7b5, 0);
`else
    check("mul_ill", bus.d_illegal, 1);
    check("mul_regw", bus.d_regWrite, 0);
`endif

    // reset asserted while in BUBBLE
    bus.ex_memRead = 1'b1;
    bus.ex_rd      = 5'd1;
    drive(32'h00208133, 32'h700, 1'b1, "add_rst");
    tick();
    check("rb_bubble", bus.d_valid, 0);
    bus.ex_hold = 1'b1;
    #1 check("rb_hold_stall", bus.stall, 1);
    resetn = 1'b0;
    #1;
    check("rb_stall", bus.stall, 0);
    check("rb_valid", bus.d_valid, 0);
    check("rb_pc", bus.d_pc, 0);
    check("rb_rd", bus.d_rd, 0);
    check("rb_rs1", bus.d_rs1, 0);
    check("rb_f3", bus.d_funct3, 0);
    bus.ex_hold    = 1'b0;
    bus.ex_memRead = 1'b0;
    bus.InstrRd    = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    drive(32'h00500093, 32'h600, 1'b1, "addi_first");
    #1 check("rf_stall", bus.stall, 0);
    tick();
    check("rf_valid", bus.d_valid, 1);
    check("rf_pc", bus.d_pc, 32'h600);
    check("rf_rd", bus.d_rd, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
